// File: rtl/counter_74163_chain.sv
// STAGES cascaded 74x163 4-bit synchronous counters with CET/TC ripple carry.
// Define COUNTER_74163_TIMING_EN to model cp->q and carry-ripple delays.
module counter_74163_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned T_CQ   = 18,
  parameter int unsigned T_CLR  = 16,
  parameter int unsigned T_TC   = 11
) (
  input  logic                  cp,
  input  logic                  n_mr,
  input  logic                  n_pe,
  input  logic                  cep,
  input  logic                  cet,
  input  logic [4*STAGES-1:0]   d,
  output logic [4*STAGES-1:0]   q,
  output logic [STAGES-1:0]     stage_tc,
  output logic                  tc
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [3:0] r_q;
    logic       w_cet;
    logic       w_tc;
    logic       w_ctl_x;

    if (gi == 0) begin : g_first
      assign w_cet = cet;
    end else begin : g_next
      assign w_cet = g_stage[gi-1].w_tc;
    end

    // Any unknown control at the edge poisons this stage so undriven lines show up.
    assign w_ctl_x = ((^{n_mr, n_pe, cep, w_cet}) === 1'bx);

`ifdef COUNTER_74163_TIMING_EN
    always_ff @(posedge cp) begin
      if (w_ctl_x)            r_q <= #(T_CQ)  'x;
      else if (!n_mr)         r_q <= #(T_CLR) '0;
      else if (!n_pe)         r_q <= #(T_CQ)  d[4*gi +: 4];
      else if (cep && w_cet)  r_q <= #(T_CQ)  r_q + 4'd1;
    end

    assign #(T_TC) w_tc = w_cet & (r_q == 4'hF);
`else
    always_ff @(posedge cp) begin
      if (w_ctl_x)            r_q <= 'x;
      else if (!n_mr)         r_q <= '0;
      else if (!n_pe)         r_q <= d[4*gi +: 4];
      else if (cep && w_cet)  r_q <= r_q + 4'd1;
    end

    assign w_tc = w_cet & (r_q == 4'hF);
`endif

    assign q[4*gi +: 4] = r_q;
    assign stage_tc[gi] = w_tc;
  end

  assign tc = stage_tc[STAGES-1];

endmodule

// File: tb/tb_counter_74163_chain.sv
// Self-checking bench for counter_74163_chain: directed vector table, hand
// sequences for the combinational carry, and random stimulus vs a W-bit model.
module tb_counter_74163_chain;

  localparam int unsigned STAGES = 4;
  localparam int unsigned W      = 4 * STAGES;

  logic          cp = 1'b0;
  logic          n_mr, n_pe, cep, cet;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [STAGES-1:0] stage_tc;
  logic          tc;

  int errors = 0;
  int checks = 0;

  counter_74163_chain #(.STAGES(STAGES)) dut (
    .cp       (cp),
    .n_mr     (n_mr),
    .n_pe     (n_pe),
    .cep      (cep),
    .cet      (cet),
    .d        (d),
    .q        (q),
    .stage_tc (stage_tc),
    .tc       (tc)
  );

  always #5 cp = ~cp;

  typedef struct {
    logic              n_mr;
    logic              n_pe;
    logic              cep;
    logic              cet;
    logic [W-1:0]      d;
    logic [W-1:0]      exp_q;
    logic [STAGES-1:0] exp_stc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: stage i reports terminal count when the trickle input is high
  // and every bit of the low 4*(i+1) bits of the counter is one.
  function automatic logic [STAGES-1:0] model_stc(input logic [W-1:0] v, input logic ce);
    logic [STAGES-1:0] r;
    longint unsigned mask;
    r = '0;
    for (int i = 0; i < STAGES; i++) begin
      mask = (64'd1 << (4 * (i + 1))) - 1;
      r[i] = ce && ((longint'(v) & mask) == mask);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic drive(input logic mr, input logic pe, input logic ep, input logic et,
                       input logic [W-1:0] dv);
    n_mr = mr; n_pe = pe; cep = ep; cet = et; d = dv;
  endtask

  vec_t vecs[11];
  logic [W-1:0] m_q;
  logic [STAGES-1:0] m_stc;
  logic r_mr, r_pe, r_ep, r_et;
  logic [W-1:0] r_d;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'hFFFE, 4'b0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'hFFFF, 4'b1111};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h0000, 4'b0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'h00FF, 4'b0011};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h0100, 4'b0000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h000F, 16'h000F, 4'b0001};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h000F, 4'b0001};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0042, 4'b0000};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'b0000};

    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    #2;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].n_mr, vecs[i].n_pe, vecs[i].cep, vecs[i].cet, vecs[i].d);
      tick();
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_stc", i), 32'(stage_tc), 32'(vecs[i].exp_stc));
      check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_stc[STAGES-1]));
    end

    // Terminal count follows cet with no clock, independent of cep.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h000F);
    tick();
    check("hold_f_stc", 32'(stage_tc), 32'(4'b0001));
    cet = 1'b0;
    #1;
    check("cet_drop_stc", 32'(stage_tc), 32'(4'b0000));
    cet = 1'b1;
    #1;
    check("cet_rise_stc", 32'(stage_tc), 32'(4'b0001));

    // Carry ripples combinationally through all lower stages before the edge.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0FFF);
    tick();
    check("pre_0fff_stc", 32'(stage_tc), 32'(4'b0111));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    tick();
    check("carry_0fff_q", 32'(q), 32'(16'h1000));

    // Glitches on load/data between edges must not disturb q.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    #2; n_pe = 1'b0; d = 16'hABCD;
    #2; n_pe = 1'b1; d = 16'h0000;
    tick();
    check("between_edges_q", 32'(q), 32'(16'h1000));

    // Random stimulus against the whole-counter arithmetic model.
    m_q = q;
    for (int n = 0; n < 400; n++) begin
      r_mr = ($urandom_range(0, 24) != 0);
      r_pe = ($urandom_range(0, 7) != 0);
      r_ep = ($urandom_range(0, 3) != 0);
      r_et = ($urandom_range(0, 4) != 0);
      r_d  = W'($urandom);
      if ($urandom_range(0, 1) == 1) r_d = r_d | 16'hFFC0;
      drive(r_mr, r_pe, r_ep, r_et, r_d);
      #1;
      m_stc = model_stc(m_q, r_et);
      check($sformatf("rnd%0d_pre_stc", n), 32'(stage_tc), 32'(m_stc));
      if (!r_mr)              m_q = '0;
      else if (!r_pe)         m_q = r_d;
      else if (r_ep && r_et)  m_q = m_q + 1'b1;
      tick();
      m_stc = model_stc(m_q, r_et);
      check($sformatf("rnd%0d_q", n), 32'(q), 32'(m_q));
      check($sformatf("rnd%0d_tc", n), 32'(tc), 32'(m_stc[STAGES-1]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
